fp_addsub_seq: RTL

FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

---
 rtl/fp_addsub_seq.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single add/sub with truncation and flush-to-zero of denormals.
// Latency 4+n cycles from start to done (n = normalisation shifts, 0..23).
// No backpressure: start is taken only in IDLE; busy flags that the unit cannot accept work.
module fp_addsub_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [2:0] {IDLE, ALIGN, ADDSUB, NORM, DONE} state_t;
   state_t state, state_nxt;

   logic [31:0] ra, rb;
   logic        rop;
   logic        sx, sub, nan;
   logic [8:0]  ex;
   logic [23:0] mx, my, mant;

   logic [7:0]  ea, eb, ehi, elo, dexp;
   logic [23:0] ma, mb, mhi, mlo, my_sh;
   logic        sbe, a_ge_b, norm_shift;
   logic [24:0] sum;
   logic [31:0] res_nxt;

   // Operand decode and ordering; B's sign is folded with op so X-Y is always the magnitude op
   always_comb begin
      ea     = ra[30:23];
      eb     = rb[30:23];
      ma     = (ea == 8'd0) ? 24'd0 : {1'b1, ra[22:0]};
      mb     = (eb == 8'd0) ? 24'd0 : {1'b1, rb[22:0]};
      sbe    = rb[31] ^ rop;
      a_ge_b = {ea, ma} >= {eb, mb};
      ehi    = a_ge_b ? ea : eb;
      elo    = a_ge_b ? eb : ea;
      mhi    = a_ge_b ? ma : mb;
      mlo    = a_ge_b ? mb : ma;
      dexp   = ehi - elo;
      my_sh  = (dexp >= 8'd24) ? 24'd0 : (mlo >> dexp);
   end

   always_comb begin
      sum        = sub ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});
      norm_shift = !mant[23] && (mant != 24'd0) && (ex > 9'd1);
      if (nan)
         res_nxt = 32'h7FC0_0000;
      else if (mant == 24'd0)
         res_nxt = 32'h0000_0000;
      else if (ex >= 9'd255)
         res_nxt = {sx, 8'hFF, 23'd0};
      else if (!mant[23])
         res_nxt = 32'h0000_0000;
      else
         res_nxt = {sx, ex[7:0], mant[22:0]};
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      done      = (state == DONE);
      case (state)
         IDLE:    if (start) state_nxt = ALIGN;
         ALIGN:   state_nxt = ADDSUB;
         ADDSUB:  state_nxt = NORM;
         NORM:    if (!norm_shift) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result <= 32'h0000_0000;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  ra  <= a;
                  rb  <= b;
                  rop <= op;
               end
            end
            ALIGN: begin
               sx  <= a_ge_b ? ra[31] : sbe;
               sub <= ra[31] ^ sbe;
               nan <= (ea == 8'hFF) || (eb == 8'hFF);
               ex  <= {1'b0, ehi};
               mx  <= mhi;
               my  <= my_sh;
            end
            ADDSUB: begin
               if (sum[24]) begin
                  mant <= sum[24:1];
                  ex   <= ex + 9'd1;
               end else begin
                  mant <= sum[23:0];
               end
            end
            NORM: begin
               // Result is registered on NORM exit so it is already valid while done is high
               if (norm_shift) begin
                  mant <= {mant[22:0], 1'b0};
                  ex   <= ex - 9'd1;
               end else begin
                  result <= res_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
